// File: rtl/round_ctrl_pkg.sv
// rtl/round_ctrl_pkg.sv - round controller state encoding and default parameters
package round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GEN    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_PAUSE  = 3'd4,
      ST_DONE   = 3'd5
   } round_state_t;

   localparam int DEF_ROUND_FRAMES  = 600;
   localparam int DEF_GRACE_FRAMES  = 3;
   localparam int DEF_SETTLE_FRAMES = 30;

endpackage

// File: rtl/frame_down_counter.sv
// rtl/frame_down_counter.sv - loadable frame down-counter with tick enable, freeze and zero flag
// Load has priority over ticking; the count stops at zero instead of wrapping.
module frame_down_counter #(
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick_en,
   input  logic             freeze,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (tick_en && !freeze && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - game round sequencer: level regen, settle delay, timed run, pause, result
// Build option ROUND_CTRL_GRACE_EN: tolerate up to GRACE_FRAMES-1 consecutive unsafe frames.
module round_controller
   import round_ctrl_pkg::*;
#(
   parameter int ROUND_FRAMES  = DEF_ROUND_FRAMES,
   parameter int GRACE_FRAMES  = DEF_GRACE_FRAMES,
   parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start,
   input  logic                              i_pause,
   input  logic                              i_frame_tick,
   input  logic                              i_ball_safe,
   input  logic                              i_zone_rdy,
   output logic                              o_regenerate_level,
   output logic                              o_round_ended,
   output logic                              o_is_win,
   output logic [$clog2(ROUND_FRAMES+1)-1:0] o_time_left,
   output logic                              o_running
);

   localparam int TW = $clog2(ROUND_FRAMES + 1);
   localparam int SW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
   localparam logic [TW-1:0] ROUND_LOAD  = TW'(ROUND_FRAMES);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_FRAMES);

   round_state_t  state, state_nxt;
   logic [SW-1:0] settle_count;
   logic          settle_zero;
   logic          settle_load;
   logic          time_zero;
   logic          time_load;
   logic          run_tick;
   logic          unsafe_lose;
   logic          round_lose;
   logic          round_win;

   // Pause has priority over a coincident frame tick, so the tick is simply lost.
   assign run_tick    = (state == ST_RUN) && i_frame_tick && !i_pause;
   assign settle_load = (state == ST_GEN) && (state_nxt == ST_SETTLE);
   assign time_load   = (state == ST_SETTLE) && (state_nxt == ST_RUN);

   frame_down_counter #(.WIDTH(SW), .RESET_VAL('0)) u_settle_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (settle_load),
      .load_val (SETTLE_LOAD),
      .tick_en  (i_frame_tick && (state == ST_SETTLE)),
      .freeze   (1'b0),
      .count    (settle_count),
      .zero     (settle_zero)
   );

   frame_down_counter #(.WIDTH(TW), .RESET_VAL(ROUND_LOAD)) u_round_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (time_load),
      .load_val (ROUND_LOAD),
      .tick_en  (i_frame_tick && (state == ST_RUN)),
      .freeze   (i_pause),
      .count    (o_time_left),
      .zero     (time_zero)
   );

`ifdef ROUND_CTRL_GRACE_EN
   localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
   localparam logic [GW-1:0] GRACE_LIMIT = GW'(GRACE_FRAMES);

   logic [GW-1:0] unsafe_count, unsafe_nxt;

   always_comb begin
      unsafe_nxt = unsafe_count;
      if (i_ball_safe) begin
         unsafe_nxt = '0;
      end else if (unsafe_count < GRACE_LIMIT) begin
         unsafe_nxt = unsafe_count + GW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || time_load) begin
         unsafe_count <= '0;
      end else if (run_tick) begin
         unsafe_count <= unsafe_nxt;
      end
   end

   assign unsafe_lose = (unsafe_nxt >= GRACE_LIMIT);
`else
   assign unsafe_lose = !i_ball_safe;
`endif

   // A loss on the same tick that empties the timer takes precedence over the win.
   assign round_lose = run_tick && unsafe_lose;
   assign round_win  = !round_lose &&
                       (time_zero || (run_tick && (o_time_left == TW'(1))));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_GEN;
         // o_regenerate_level is high only in the first GEN cycle, which masks i_zone_rdy there.
         ST_GEN:    if (!o_regenerate_level && i_zone_rdy) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_zero || (i_frame_tick && (settle_count == SW'(1))))
                       state_nxt = ST_RUN;
         ST_RUN: begin
            if (i_pause) begin
               state_nxt = ST_PAUSE;
            end else if (round_lose || round_win) begin
               state_nxt = ST_DONE;
            end
         end
         ST_PAUSE:  if (i_start && !i_pause) state_nxt = ST_RUN;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         o_regenerate_level <= 1'b0;
         o_round_ended      <= 1'b0;
         o_is_win           <= 1'b0;
         o_running          <= 1'b0;
      end else begin
         state              <= state_nxt;
         o_regenerate_level <= (state_nxt == ST_GEN) && (state != ST_GEN);
         o_round_ended      <= (state_nxt == ST_DONE) && (state != ST_DONE);
         o_running          <= (state_nxt == ST_RUN);
         if ((state_nxt == ST_GEN) && (state != ST_GEN)) begin
            o_is_win <= 1'b0;
         end else if ((state == ST_RUN) && (state_nxt == ST_DONE)) begin
            o_is_win <= !round_lose;
         end
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller
module tb_round_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start, i_pause, i_frame_tick, i_ball_safe, i_zone_rdy;
   logic       o_regenerate_level, o_round_ended, o_is_win, o_running;
   logic [9:0] o_time_left;

   logic       b_start, b_zone_rdy;
   logic       b_regen, b_ended, b_win, b_running;
   logic [1:0] b_time_left;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   round_controller dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause),
      .i_frame_tick(i_frame_tick), .i_ball_safe(i_ball_safe), .i_zone_rdy(i_zone_rdy),
      .o_regenerate_level(o_regenerate_level), .o_round_ended(o_round_ended),
      .o_is_win(o_is_win), .o_time_left(o_time_left), .o_running(o_running)
   );

   round_controller #(.ROUND_FRAMES(3), .GRACE_FRAMES(3), .SETTLE_FRAMES(0)) dut_short (
      .clk(clk), .rst(rst), .i_start(b_start), .i_pause(i_pause),
      .i_frame_tick(i_frame_tick), .i_ball_safe(i_ball_safe), .i_zone_rdy(b_zone_rdy),
      .o_regenerate_level(b_regen), .o_round_ended(b_ended),
      .o_is_win(b_win), .o_time_left(b_time_left), .o_running(b_running)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic safe);
      i_frame_tick = 1'b1;
      i_ball_safe  = safe;
      cycle();
      i_frame_tick = 1'b0;
      i_ball_safe  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      total++; if (o_time_left !== 10'd600) $display("FAIL reset_time_left: got %0d want 600", o_time_left); else passed++;
      total++; if ({o_regenerate_level, o_round_ended, o_is_win, o_running} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {o_regenerate_level, o_round_ended, o_is_win, o_running}); else passed++;
      total++; if (b_time_left !== 2'd3) $display("FAIL reset_short_time: got %0d want 3", b_time_left); else passed++;
      rst = 1'b0;
      cycle();
      total++; if ({o_regenerate_level, o_round_ended, b_regen, b_ended} !== 4'b0000)
         $display("FAIL reset_release_pulses: got %b want 0000", {o_regenerate_level, o_round_ended, b_regen, b_ended}); else passed++;
   endtask

   task automatic start_round(input string tag);
      int regen_pulses;
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      regen_pulses = int'(o_regenerate_level);
      total++; if (o_is_win !== 1'b0) $display("FAIL %s_win_cleared: got %b want 0", tag, o_is_win); else passed++;
      for (int c = 0; c < 3; c++) begin
         cycle();
         regen_pulses += int'(o_regenerate_level);
      end
      i_zone_rdy = 1'b1;
      cycle();
      regen_pulses += int'(o_regenerate_level);
      i_zone_rdy = 1'b0;
      total++; if (regen_pulses != 1) $display("FAIL %s_regen_pulses: got %0d want 1", tag, regen_pulses); else passed++;
      for (int t = 0; t < 29; t++) do_tick(1'b1);
      total++; if (o_running !== 1'b0) $display("FAIL %s_settle_29: got running=%b want 0", tag, o_running); else passed++;
      do_tick(1'b1);
      total++; if (o_running !== 1'b1) $display("FAIL %s_settle_30: got running=%b want 1", tag, o_running); else passed++;
      total++; if (o_time_left !== 10'd600) $display("FAIL %s_run_time: got %0d want 600", tag, o_time_left); else passed++;
   endtask

   task automatic test_win_with_pause();
      start_round("bringup");
      for (int t = 0; t < 500; t++) do_tick(1'b1);
      total++; if (o_time_left !== 10'd100) $display("FAIL run_500_ticks: got %0d want 100", o_time_left); else passed++;
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      total++; if ({o_running, o_regenerate_level, o_time_left} !== {2'b10, 10'd100})
         $display("FAIL start_in_run_ignored: got run=%b regen=%b time=%0d want 1 0 100", o_running, o_regenerate_level, o_time_left); else passed++;
      i_pause = 1'b1;
      do_tick(1'b0);
      i_pause = 1'b0;
      total++; if ({o_running, o_time_left} !== {1'b0, 10'd100})
         $display("FAIL pause_with_tick: got run=%b time=%0d want 0 100", o_running, o_time_left); else passed++;
      for (int t = 0; t < 50; t++) do_tick(1'b0);
      total++; if ({o_running, o_round_ended, o_time_left} !== {2'b00, 10'd100})
         $display("FAIL pause_hold: got run=%b ended=%b time=%0d want 0 0 100", o_running, o_round_ended, o_time_left); else passed++;
      i_pause = 1'b1;
      i_start = 1'b1;
      cycle();
      i_pause = 1'b0;
      total++; if (o_running !== 1'b0) $display("FAIL pause_and_start: got running=%b want 0", o_running); else passed++;
      cycle();
      i_start = 1'b0;
      total++; if ({o_running, o_time_left} !== {1'b1, 10'd100})
         $display("FAIL resume: got run=%b time=%0d want 1 100", o_running, o_time_left); else passed++;
      for (int t = 0; t < 99; t++) do_tick(1'b1);
      total++; if ({o_round_ended, o_time_left} !== {1'b0, 10'd1})
         $display("FAIL win_minus_one: got ended=%b time=%0d want 0 1", o_round_ended, o_time_left); else passed++;
      do_tick(1'b1);
      total++; if ({o_round_ended, o_is_win, o_running, o_time_left} !== {3'b110, 10'd0})
         $display("FAIL win_end: got ended=%b win=%b run=%b time=%0d want 1 1 0 0", o_round_ended, o_is_win, o_running, o_time_left); else passed++;
      cycle();
      total++; if ({o_round_ended, o_is_win} !== 2'b01)
         $display("FAIL win_after: got ended=%b win=%b want 0 1", o_round_ended, o_is_win); else passed++;
   endtask

   task automatic test_lose();
      start_round("lose");
`ifdef ROUND_CTRL_GRACE_EN
      do_tick(1'b0);
      do_tick(1'b0);
      do_tick(1'b1);
      do_tick(1'b0);
      do_tick(1'b0);
      total++; if ({o_round_ended, o_running, o_time_left} !== {2'b01, 10'd595})
         $display("FAIL lose_grace_hold: got ended=%b run=%b time=%0d want 0 1 595", o_round_ended, o_running, o_time_left); else passed++;
      do_tick(1'b0);
      total++; if ({o_round_ended, o_is_win, o_running, o_time_left} !== {3'b100, 10'd594})
         $display("FAIL lose_end: got ended=%b win=%b run=%b time=%0d want 1 0 0 594", o_round_ended, o_is_win, o_running, o_time_left); else passed++;
`else
      do_tick(1'b0);
      total++; if ({o_round_ended, o_is_win, o_running, o_time_left} !== {3'b100, 10'd599})
         $display("FAIL lose_end: got ended=%b win=%b run=%b time=%0d want 1 0 0 599", o_round_ended, o_is_win, o_running, o_time_left); else passed++;
`endif
      cycle();
      cycle();
      total++; if ({o_round_ended, o_is_win, o_running} !== 3'b000)
         $display("FAIL lose_done_hold: got ended=%b win=%b run=%b want 0 0 0", o_round_ended, o_is_win, o_running); else passed++;
   endtask

   task automatic test_short_round_tie();
      b_start    = 1'b1;
      b_zone_rdy = 1'b1;
      cycle();
      b_start = 1'b0;
      total++; if (b_regen !== 1'b1) $display("FAIL short_regen: got %b want 1", b_regen); else passed++;
      cycle();
      cycle();
      total++; if ({b_regen, b_running} !== 2'b00)
         $display("FAIL short_gen_first_ignored: got regen=%b run=%b want 0 0", b_regen, b_running); else passed++;
      cycle();
      b_zone_rdy = 1'b0;
      total++; if ({b_running, b_time_left} !== {1'b1, 2'd3})
         $display("FAIL short_settle_zero: got run=%b time=%0d want 1 3", b_running, b_time_left); else passed++;
`ifdef ROUND_CTRL_GRACE_EN
      do_tick(1'b0);
      do_tick(1'b0);
`else
      do_tick(1'b1);
      do_tick(1'b1);
`endif
      total++; if ({b_ended, b_time_left} !== {1'b0, 2'd1})
         $display("FAIL short_before_tie: got ended=%b time=%0d want 0 1", b_ended, b_time_left); else passed++;
      do_tick(1'b0);
      total++; if ({b_ended, b_win, b_running, b_time_left} !== {3'b100, 2'd0})
         $display("FAIL short_tie_loses: got ended=%b win=%b run=%b time=%0d want 1 0 0 0", b_ended, b_win, b_running, b_time_left); else passed++;
   endtask

   task automatic test_reset_mid_run();
      start_round("midrst");
      for (int t = 0; t < 5; t++) do_tick(1'b1);
      total++; if (o_time_left !== 10'd595) $display("FAIL midrst_time: got %0d want 595", o_time_left); else passed++;
      rst          = 1'b1;
      i_frame_tick = 1'b1;
      i_ball_safe  = 1'b0;
      cycle();
      i_frame_tick = 1'b0;
      i_ball_safe  = 1'b1;
      total++; if ({o_regenerate_level, o_round_ended, o_is_win, o_running, o_time_left} !== {4'b0000, 10'd600})
         $display("FAIL midrst_outputs: got regen=%b ended=%b win=%b run=%b time=%0d want 0 0 0 0 600",
                  o_regenerate_level, o_round_ended, o_is_win, o_running, o_time_left); else passed++;
      rst = 1'b0;
      cycle();
      total++; if ({o_regenerate_level, o_round_ended, o_running} !== 3'b000)
         $display("FAIL midrst_release: got regen=%b ended=%b run=%b want 0 0 0", o_regenerate_level, o_round_ended, o_running); else passed++;
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      total++; if (o_regenerate_level !== 1'b1) $display("FAIL midrst_restart: got regen=%b want 1", o_regenerate_level); else passed++;
   endtask

   initial begin
      rst          = 1'b1;
      i_start      = 1'b0;
      i_pause      = 1'b0;
      i_frame_tick = 1'b0;
      i_ball_safe  = 1'b1;
      i_zone_rdy   = 1'b0;
      b_start      = 1'b0;
      b_zone_rdy   = 1'b0;
      test_reset();
      test_win_with_pause();
      test_lose();
      test_short_round_tie();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
